// File: rtl/snake_pkg.sv
// Shared definitions for the snake body controller: direction codes, FSM
// states and helpers that pack/unpack {x,y} coordinate words.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_INIT,
    ST_IDLE,
    ST_STEP,
    ST_DONE,
    ST_OVER
  } state_t;

  // Widest coordinate the helpers handle; callers cast to their own width.
  localparam int unsigned MAX_CW = 16;

  function automatic logic [2*MAX_CW-1:0] coord_mask(input int unsigned cw);
    return (32'(1) << cw) - 32'(1);
  endfunction

  // {x,y} with x in the upper cw bits and y in the lower cw bits.
  function automatic logic [2*MAX_CW-1:0] pack_xy(input logic [MAX_CW-1:0] x,
                                                  input logic [MAX_CW-1:0] y,
                                                  input int unsigned       cw);
    logic [2*MAX_CW-1:0] mask;
    mask = coord_mask(cw);
    return ((32'(x) & mask) << cw) | (32'(y) & mask);
  endfunction

  function automatic logic [MAX_CW-1:0] unpack_x(input logic [2*MAX_CW-1:0] w,
                                                 input int unsigned         cw);
    return MAX_CW'((w >> cw) & coord_mask(cw));
  endfunction

  function automatic logic [MAX_CW-1:0] unpack_y(input logic [2*MAX_CW-1:0] w,
                                                 input int unsigned         cw);
    return MAX_CW'(w & coord_mask(cw));
  endfunction

  // Up/down and left/right differ only in bit 1 of the direction code.
  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a ^ 2'b10) == b;
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculator: moves the head one cell in cur_dir and
// flags a move that would leave the playfield (the head is then held).
module snake_next_head
  import snake_pkg::*;
#(
  parameter int CW     = 8,
  parameter int GRID_W = 40,
  parameter int GRID_H = 30
) (
  input  logic [1:0]    cur_dir,
  input  logic [CW-1:0] head_x,
  input  logic [CW-1:0] head_y,
  output logic [CW-1:0] next_x,
  output logic [CW-1:0] next_y,
  output logic          out_of_bounds
);

  localparam logic [CW-1:0] X_MAX = CW'(GRID_W - 1);
  localparam logic [CW-1:0] Y_MAX = CW'(GRID_H - 1);

  // Step one cell, refusing to cross a wall.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    next_x        = head_x;
    next_y        = head_y;
    out_of_bounds = 1'b0;
    case (cur_dir)
      DIR_UP: begin
        if (head_y == '0) out_of_bounds = 1'b1;
        else              next_y = head_y - CW'(1);
      end
      DIR_RIGHT: begin
        if (head_x == X_MAX) out_of_bounds = 1'b1;
        else                 next_x = head_x + CW'(1);
      end
      DIR_DOWN: begin
        if (head_y == Y_MAX) out_of_bounds = 1'b1;
        else                 next_y = head_y + CW'(1);
      end
      default: begin
        if (head_x == '0) out_of_bounds = 1'b1;
        else              next_x = head_x - CW'(1);
      end
    endcase
  end

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake body sequencer: seeds the body FIFO, then on each game tick pushes the
// new head and pops the tail (unless growing), stopping at a wall collision.
module snake_body_ctrl
  import snake_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30,
  parameter int START_X    = 20,
  parameter int START_Y    = 15,
  parameter int INIT_LEN   = 3,
  parameter int MAX_LEN    = 63
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           tick,
  input  logic [1:0]                     dir,
  input  logic                           eat,
  input  logic                           restart,
  output logic                           fifo_write,
  output logic                           fifo_read,
  output logic [DATA_WIDTH-1:0]          fifo_wdata,
  input  logic [DATA_WIDTH-1:0]          fifo_rdata,
  input  logic                           fifo_empty,
  output logic                           fifo_rstn,
  output logic [DATA_WIDTH/2-1:0]        head_x,
  output logic [DATA_WIDTH/2-1:0]        head_y,
  output logic [DATA_WIDTH/2-1:0]        tail_x,
  output logic [DATA_WIDTH/2-1:0]        tail_y,
  output logic                           tail_valid,
  output logic [$clog2(MAX_LEN+1)-1:0]   length,
  output logic                           step_done,
  output logic                           game_over,
  output logic                           busy
);

  localparam int CW   = DATA_WIDTH / 2;
  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int CNTW = $clog2(INIT_LEN + 1);

  state_t          state, state_nxt;
  logic [1:0]      cur_dir;
  logic            grow_pending;
  logic [CNTW-1:0] init_cnt;

  logic [CW-1:0]   next_x, next_y;
  logic            oob;
  logic            init_last;
  logic            grow_take;
  logic            grow_spend;
  logic            pop_now;
  logic [DATA_WIDTH-1:0] init_word, next_word;

  logic                  fifo_write_d, fifo_read_d, fifo_rstn_d;
  logic                  tail_valid_d, step_done_d, busy_d;
  logic [DATA_WIDTH-1:0] fifo_wdata_d;

  snake_next_head #(
    .CW     (CW),
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_next_head (
    .cur_dir       (cur_dir),
    .head_x        (head_x),
    .head_y        (head_y),
    .next_x        (next_x),
    .next_y        (next_y),
    .out_of_bounds (oob)
  );

  assign init_last  = (init_cnt == CNTW'(INIT_LEN - 1));
  assign grow_take  = grow_pending && (length < LW'(MAX_LEN));
  assign grow_spend = (state == ST_STEP) && !oob && grow_take;
  assign pop_now    = !grow_take && !fifo_empty;

  // Seed body is laid out tail first, ending at the start cell.
  assign init_word = DATA_WIDTH'(pack_xy(16'(START_X - INIT_LEN + 1) + 16'(init_cnt),
                                         16'(START_Y), CW));
  assign next_word = DATA_WIDTH'(pack_xy(16'(next_x), 16'(next_y), CW));

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) state <= ST_CLEAR;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: state_nxt = ST_INIT;
      ST_INIT:  if (init_last) state_nxt = ST_IDLE;
      ST_IDLE:  if (tick) state_nxt = ST_STEP;
      ST_STEP:  state_nxt = oob ? ST_OVER : ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      ST_OVER:  if (restart) state_nxt = ST_CLEAR;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // Output decode: what each registered output shows during the next cycle.
  always_comb begin
    fifo_write_d = 1'b0;
    fifo_read_d  = 1'b0;
    fifo_wdata_d = '0;
    fifo_rstn_d  = 1'b1;
    tail_valid_d = 1'b0;
    step_done_d  = 1'b0;
    busy_d       = (state_nxt != ST_IDLE) && (state_nxt != ST_OVER);
    case (state)
      ST_CLEAR: fifo_rstn_d = 1'b0;
      ST_INIT: begin
        fifo_write_d = 1'b1;
        fifo_wdata_d = init_word;
      end
      ST_STEP: begin
        if (!oob) begin
          fifo_write_d = 1'b1;
          fifo_wdata_d = next_word;
          fifo_read_d  = pop_now;
          tail_valid_d = pop_now;
        end
      end
      ST_DONE: step_done_d = 1'b1;
      default: ;
    endcase
  end

  // Output registers; strobes land one cycle after the state that decided them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_write <= 1'b0;
      fifo_read  <= 1'b0;
      fifo_wdata <= '0;
      fifo_rstn  <= 1'b1;
      tail_valid <= 1'b0;
      step_done  <= 1'b0;
      busy       <= 1'b1;
    end else begin
      fifo_write <= fifo_write_d;
      fifo_read  <= fifo_read_d;
      fifo_wdata <= fifo_wdata_d;
      fifo_rstn  <= fifo_rstn_d;
      tail_valid <= tail_valid_d;
      step_done  <= step_done_d;
      busy       <= busy_d;
    end
  end

  // Food capture: sticky until a successful STEP spends it on growth.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grow_pending <= 1'b0;
    end else if (state == ST_CLEAR) begin
      grow_pending <= 1'b0;
    end else if (state == ST_IDLE || state == ST_STEP || state == ST_DONE) begin
      grow_pending <= (grow_pending && !grow_spend) || eat;
    end
  end

  // Game datapath: seed counter, direction, head, tail, length, collision flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      init_cnt  <= '0;
      cur_dir   <= DIR_RIGHT;
      head_x    <= '0;
      head_y    <= '0;
      tail_x    <= '0;
      tail_y    <= '0;
      length    <= '0;
      game_over <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          init_cnt  <= '0;
          length    <= '0;
          game_over <= 1'b0;
        end
        ST_INIT: begin
          init_cnt <= init_cnt + CNTW'(1);
          if (init_last) begin
            head_x  <= CW'(START_X);
            head_y  <= CW'(START_Y);
            length  <= LW'(INIT_LEN);
            cur_dir <= DIR_RIGHT;
          end
        end
        ST_IDLE: begin
          if (tick && !is_reverse(dir, cur_dir)) cur_dir <= dir;
        end
        ST_STEP: begin
          if (oob) begin
            game_over <= 1'b1;
          end else begin
            head_x <= next_x;
            head_y <= next_y;
            if (grow_take) begin
              length <= length + LW'(1);
            end else if (!fifo_empty) begin
              tail_x <= CW'(unpack_x(32'(fifo_rdata), CW));
              tail_y <= CW'(unpack_y(32'(fifo_rdata), CW));
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Bench for snake_body_ctrl: a behavioural FIFO model answers the DUT's
// strobes, a reference snake model feeds a scoreboard of expected steps, and
// a hand-derived vector table pins down the first moves.
module tb_snake_body_ctrl;

  localparam int DW = 16;
  localparam int GW = 40;
  localparam int GH = 30;
  localparam int SX = 20;
  localparam int SY = 15;
  localparam int IL = 3;
  localparam int ML = 63;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] dir = 2'd1;
  logic       eat = 1'b0;
  logic       restart = 1'b0;
  logic       fifo_write, fifo_read, fifo_rstn;
  logic [DW-1:0] fifo_wdata;
  logic [DW-1:0] fifo_rdata = '0;
  logic       fifo_empty = 1'b1;
  logic [7:0] head_x, head_y, tail_x, tail_y;
  logic [5:0] length;
  logic       tail_valid, step_done, game_over, busy;

  always #5 clk = ~clk;

  snake_body_ctrl #(
    .DATA_WIDTH (DW), .GRID_W (GW), .GRID_H (GH),
    .START_X (SX), .START_Y (SY), .INIT_LEN (IL), .MAX_LEN (ML)
  ) dut (
    .clk (clk), .rstn (rstn), .tick (tick), .dir (dir), .eat (eat),
    .restart (restart), .fifo_write (fifo_write), .fifo_read (fifo_read),
    .fifo_wdata (fifo_wdata), .fifo_rdata (fifo_rdata), .fifo_empty (fifo_empty),
    .fifo_rstn (fifo_rstn), .head_x (head_x), .head_y (head_y),
    .tail_x (tail_x), .tail_y (tail_y), .tail_valid (tail_valid),
    .length (length), .step_done (step_done), .game_over (game_over), .busy (busy)
  );

  // Behavioural body FIFO with synchronous active-low clear.
  logic [15:0] fq[$];
  int max_occ = 0;
  int underflow = 0;
  always @(posedge clk) begin
    if (!fifo_rstn) begin
      fq.delete();
    end else begin
      if (fifo_read) begin
        if (fq.size() > 0) void'(fq.pop_front());
        else               underflow++;
      end
      if (fifo_write) fq.push_back(fifo_wdata);
    end
    if (fq.size() > max_occ) max_occ = fq.size();
    fifo_empty <= (fq.size() == 0);
    fifo_rdata <= (fq.size() > 0) ? fq[0] : 16'h0;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] xy(input int x, input int y);
    logic [7:0] a, b;
    a = 8'(x);
    b = 8'(y);
    return {a, b};
  endfunction

  // Reference snake model and scoreboard.
  typedef struct packed {
    logic [15:0] wdata;
    logic        pop;
    logic [15:0] tail;
    logic [5:0]  len;
  } exp_t;
  exp_t        exp_q[$];
  logic [15:0] mq[$];
  int          mx, my, mlen;
  logic [1:0]  mdir;
  bit          mgrow, mover;

  task automatic model_init();
    mq.delete();
    for (int i = 0; i < IL; i++) mq.push_back(xy(SX - IL + 1 + i, SY));
    mx = SX; my = SY; mdir = 2'd1; mlen = IL; mgrow = 0; mover = 0;
  endtask

  task automatic model_step(input logic [1:0] d, output bit oob);
    exp_t e;
    int nx, ny;
    if (d != (mdir ^ 2'd2)) mdir = d;
    nx = mx; ny = my;
    case (mdir)
      2'd0: ny = ny - 1;
      2'd1: nx = nx + 1;
      2'd2: ny = ny + 1;
      default: nx = nx - 1;
    endcase
    oob = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
    if (oob) begin
      mover = 1;
    end else begin
      e.wdata = xy(nx, ny);
      if (mgrow && mlen < ML) begin
        mlen++; mgrow = 0; e.pop = 0; e.tail = '0;
      end else begin
        e.pop = 1; e.tail = mq.pop_front();
      end
      mq.push_back(e.wdata);
      e.len = 6'(mlen);
      mx = nx; my = ny;
      exp_q.push_back(e);
    end
  endtask

  // One game step: optional eat pulse, then a tick held for 'hold' cycles.
  task automatic step(input logic [1:0] d, input bit e, input int hold);
    bit oob, ow, orr, otv, sd, extra;
    logic [15:0] owd, ot;
    int lat;
    exp_t ex;
    if (e) begin
      @(negedge clk); eat = 1'b1;
      @(negedge clk); eat = 1'b0;
      if (!mover) mgrow = 1;
    end
    model_step(d, oob);
    @(negedge clk); dir = d; tick = 1'b1;
    ow = 0; orr = 0; otv = 0; sd = 0; lat = 0; owd = '0; ot = '0;
    for (int c = 1; c <= 8 && !sd; c++) begin
      @(negedge clk);
      if (c >= hold) tick = 1'b0;
      if (fifo_write) begin ow = 1; owd = fifo_wdata; end
      if (fifo_read) orr = 1;
      if (tail_valid) begin otv = 1; ot = {tail_x, tail_y}; end
      if (step_done) begin sd = 1; lat = c; end
    end
    tick = 1'b0;
    if (oob) begin
      check("over_no_done", sd, 0);
      check("over_no_write", ow, 0);
      check("over_no_read", orr, 0);
      check("over_flag", game_over, 1);
      check("over_busy", busy, 0);
    end else begin
      ex = exp_q.pop_front();
      check("step_done_seen", sd, 1);
      check("step_latency", lat, 3);
      check("step_push", ow, 1);
      check("step_wdata", owd, ex.wdata);
      check("step_pop", orr, ex.pop);
      check("step_tail_valid", otv, ex.pop);
      if (ex.pop) check("step_tail", ot, ex.tail);
      check("step_len", length, ex.len);
      check("step_head", {head_x, head_y}, ex.wdata);
      check("fifo_occupancy", fq.size(), length);
      if (hold > 1) begin
        extra = 0;
        repeat (4) begin
          @(negedge clk);
          if (fifo_write || step_done) extra = 1;
        end
        check("tick_dropped_when_busy", extra, 0);
      end
    end
  endtask

  // Clear pulse followed by the seed writes, after reset release or restart.
  task automatic init_seq(input bit via_restart);
    int clr;
    bit early;
    logic [15:0] wl[$];
    clr = 0; early = 0;
    if (via_restart) restart = 1'b1;
    else             rstn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      restart = 1'b0;
      if (!fifo_rstn) clr++;
      if (fifo_write) begin
        if (clr == 0) early = 1;
        wl.push_back(fifo_wdata);
      end
    end
    check("init_clear_cycles", clr, 1);
    check("init_write_before_clear", early, 0);
    check("init_write_count", wl.size(), IL);
    for (int i = 0; i < IL && i < wl.size(); i++)
      check("init_word", wl[i], xy(SX - IL + 1 + i, SY));
    check("init_len", length, IL);
    check("init_head", {head_x, head_y}, xy(SX, SY));
    check("init_busy", busy, 0);
    check("init_game_over", game_over, 0);
    check("init_fifo_occupancy", fq.size(), IL);
    model_init();
  endtask

  typedef struct {
    logic [1:0] d;
    bit         e;
    int         hold;
    int         ex, ey, elen, etx, ety;
  } vec_t;
  vec_t tbl[7];
  logic [1:0] pat[4];

  initial begin
    bit stray;
    // dir, eat, hold, head, length, last popped tail
    tbl[0] = '{2'd1, 1'b0, 1, 21, 15, 3, 18, 15};
    tbl[1] = '{2'd2, 1'b1, 1, 21, 16, 4, 18, 15};
    tbl[2] = '{2'd2, 1'b0, 1, 21, 17, 4, 19, 15};
    tbl[3] = '{2'd1, 1'b0, 3, 22, 17, 4, 20, 15};
    tbl[4] = '{2'd3, 1'b0, 1, 23, 17, 4, 21, 15};
    tbl[5] = '{2'd0, 1'b0, 1, 23, 16, 4, 21, 16};
    tbl[6] = '{2'd3, 1'b0, 1, 22, 16, 4, 21, 17};
    pat[0] = 2'd2; pat[1] = 2'd3; pat[2] = 2'd0; pat[3] = 2'd1;

    repeat (3) @(negedge clk);
    check("rst_fifo_rstn", fifo_rstn, 1);
    check("rst_fifo_write", fifo_write, 0);
    check("rst_fifo_read", fifo_read, 0);
    check("rst_tail_valid", tail_valid, 0);
    check("rst_step_done", step_done, 0);
    check("rst_game_over", game_over, 0);
    check("rst_length", length, 0);
    check("rst_head", {head_x, head_y}, 16'h0);

    init_seq(1'b0);

    for (int i = 0; i < 7; i++) begin
      step(tbl[i].d, tbl[i].e, tbl[i].hold);
      check("tbl_head", {head_x, head_y}, xy(tbl[i].ex, tbl[i].ey));
      check("tbl_len", length, tbl[i].elen);
      check("tbl_tail", {tail_x, tail_y}, xy(tbl[i].etx, tbl[i].ety));
    end

    // Climb to the top wall, then run into it.
    for (int i = 0; i < 16; i++) step(2'd0, 1'b0, 1);
    check("wall_head", {head_x, head_y}, xy(22, 0));
    step(2'd0, 1'b0, 1);

    // Ticks and food are ignored while the game is over.
    @(negedge clk); eat = 1'b1; tick = 1'b1; dir = 2'd1;
    @(negedge clk); eat = 1'b0; tick = 1'b0;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (fifo_write || fifo_read || step_done) stray = 1;
    end
    check("over_ignores_tick", stray, 0);
    check("over_sticky", game_over, 1);
    check("over_head_held", {head_x, head_y}, xy(22, 0));

    init_seq(1'b1);
    step(2'd1, 1'b0, 1);

    // Grow to the cap on a tight square loop, then keep eating.
    for (int i = 0; i < 60; i++) step(pat[i % 4], 1'b1, 1);
    check("len_reaches_max", length, ML);
    for (int i = 60; i < 62; i++) step(pat[i % 4], 1'b1, 1);
    check("len_saturates", length, ML);
    check("fifo_max_occupancy", max_occ, ML);
    check("fifo_underflow", underflow, 0);
    check("fifo_not_empty", fifo_empty, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
